vector_write_sequencer: RTL and testbench
=========================================

Name: vector_write_sequencer

Overview:
- Memory-write sequencer for the vector ASIP's store path.
- Scalar op: emits one write of `scalar_data` to `base_address`.
- Vector op: streams the `LANES` elements of `vector_data` to consecutive addresses `base_address+i`, one element per clock.
- Sits between the execute-stage register read and the data-memory write port; `finished` tells the control unit the store is complete.

Parameters:
- LANES, 20, number of elements per vector (≥2).
- DATA_W, 10, element/scalar width in bits.
- ADDR_W, 6, memory address width in bits.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- op_type  in  1  0 = scalar store, 1 = vector store.
- vector_data  in  LANES x DATA_W  packed vector source; element i at `[i]`.
- scalar_data  in  DATA_W  scalar source.
- base_address  in  ADDR_W  first write address.
- write_data  out  DATA_W  data for the memory write port.
- write_address  out  ADDR_W  address for the memory write port.
- write_enable  out  1  memory write strobe.
- finished  out  1  store complete this cycle.

Behaviour:
- State: one element index register `idx`, width `$clog2(LANES)`. No other state.
- Reset: `rst` low clears `idx` to 0 immediately, independent of `clk`. While `rst` is low:
  - `write_enable` = 0, `finished` = 0.
  - `write_address`/`write_data` still follow the combinational rules below with `idx` = 0.
- Outputs are combinational from `op_type`, inputs and `idx`; zero-cycle latency.
- op_type = 0 (scalar):
  - `write_address` = `base_address`; `write_data` = `scalar_data`.
  - `write_enable` = 1; `finished` = 1.
  - `idx` loads 0 on every rising edge.
- op_type = 1 (vector):
  - `write_address` = (`base_address` + `idx`) mod 2^ADDR_W; `write_data` = `vector_data[idx]`; `write_enable` = 1.
  - `finished` = 1 only when `idx` == LANES-1.
  - On each rising edge: `idx` increments; if `idx` == LANES-1 it wraps to 0, so back-to-back vector stores restart automatically.
- `op_type` switching 1→0 mid-vector: scalar outputs appear at once, and the next edge clears `idx`. Switching 0→1: the vector starts at element 0.
- Reset mid-vector: the next element presented is element 0 at `base_address`.
- Address arithmetic: unsigned, wraps silently (no overflow flag).
- `base_address` and `vector_data` must be held stable by the upstream stage for the whole vector store.

Optional Feature:
- Macro: `VECTOR_WRITE_SEQUENCER_REG_OUT_EN`.
- When defined:
  - `write_data`, `write_address`, `write_enable` and `finished` are registered, adding one clock of latency to every output.
  - Reset clears all four registers to 0.
- When undefined: outputs are purely combinational as described above.
- The test plan below assumes the macro is undefined.

Test Plan:
- Scalar: rst high, op_type=0, base=34, scalar=160 → addr=34, data=160, write_enable=1, finished=1; still the same after an edge.
- Vector stream: vector_data[i]=50+i, op_type 0→1, then one edge per check → addr 35,36,37,38 with data 51,52,53,54; finished=0 throughout.
- Reset mid-vector: while at idx=4, pulse rst low between edges → addr=34, data=50 immediately; after the next edge addr=35, data=51.
- Return to scalar: op_type 1→0 at idx=1 → addr=34, data=160; next vector store starts at data=50.
- Completion and wrap: run 19 edges from idx=0 → addr=53, data=69, finished=1; next edge → addr=34, data=50, finished=0.
- Address wrap: base=62, vector op → addresses 62, 63, 0, 1 on successive cycles.

Source files
------------

// File: rtl/vector_write_sequencer.sv
// vector_write_sequencer: memory-write sequencer for scalar and LANES-element vector stores
// Optional feature macro: VECTOR_WRITE_SEQUENCER_REG_OUT_EN (registers all four outputs, +1 cycle latency)
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   op_type       0 = scalar store, 1 = vector store
//   vector_data   packed vector source, element i at [i*DATA_W +: DATA_W]
//   scalar_data   scalar source
//   base_address  first write address
//   write_data    data for the memory write port
//   write_address address for the memory write port
//   write_enable  memory write strobe
//   finished      store complete this cycle
module vector_write_sequencer #(
    parameter int LANES  = 20,
    parameter int DATA_W = 10,
    parameter int ADDR_W = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      op_type,
    input  logic [LANES*DATA_W-1:0]   vector_data,
    input  logic [DATA_W-1:0]         scalar_data,
    input  logic [ADDR_W-1:0]         base_address,
    output logic [DATA_W-1:0]         write_data,
    output logic [ADDR_W-1:0]         write_address,
    output logic                      write_enable,
    output logic                      finished
);
    localparam int IW = $clog2(LANES);
    localparam logic [IW-1:0] LAST = IW'(LANES - 1);

    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] elems [LANES];
    logic [DATA_W-1:0] c_data;
    logic [ADDR_W-1:0] c_addr;
    logic              c_we;
    logic              c_fin;
    logic              at_last;

    for (genvar i = 0; i < LANES; i++) begin : g_unpack
        assign elems[i] = vector_data[i*DATA_W +: DATA_W];
    end

    assign at_last = idx == LAST;

    always_comb begin
        c_addr = op_type ? base_address + ADDR_W'(idx) : base_address;
        c_data = op_type ? elems[idx] : scalar_data;
        c_we   = rst;
        c_fin  = rst & (~op_type | at_last);
    end

    // Scalar ops and the final lane both return to element 0, so back-to-back vectors restart cleanly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            idx <= '0;
        else
            idx <= (!op_type || at_last) ? '0 : idx + 1'b1;
    end

`ifdef VECTOR_WRITE_SEQUENCER_REG_OUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_data    <= '0;
            write_address <= '0;
            write_enable  <= 1'b0;
            finished      <= 1'b0;
        end else begin
            write_data    <= c_data;
            write_address <= c_addr;
            write_enable  <= c_we;
            finished      <= c_fin;
        end
    end
`else
    assign write_data    = c_data;
    assign write_address = c_addr;
    assign write_enable  = c_we;
    assign finished      = c_fin;
`endif
endmodule

// File: tb/tb_vector_write_sequencer.sv
// tb_vector_write_sequencer: table-driven and randomized self-checking bench for vector_write_sequencer
module tb_vector_write_sequencer;
    localparam int LANES  = 20;
    localparam int DATA_W = 10;
    localparam int ADDR_W = 6;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    op_type = 1'b0;
    logic [LANES*DATA_W-1:0] vector_data = '0;
    logic [DATA_W-1:0]       scalar_data = '0;
    logic [ADDR_W-1:0]       base_address = '0;
    logic [DATA_W-1:0]       write_data;
    logic [ADDR_W-1:0]       write_address;
    logic                    write_enable;
    logic                    finished;

    int checks = 0;
    int errors = 0;

    vector_write_sequencer #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .op_type(op_type), .vector_data(vector_data),
        .scalar_data(scalar_data), .base_address(base_address), .write_data(write_data),
        .write_address(write_address), .write_enable(write_enable), .finished(finished)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit r;
        bit op;
        int base;
        int ea;
        int ed;
        bit we;
        bit fin;
        int post;
    } row_t;

    row_t tbl[21];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int ea, input int ed, input bit we, input bit fin);
        chk({tag, " addr"}, 32'(write_address), ea);
        chk({tag, " data"}, 32'(write_data), ed);
        chk({tag, " we"}, 32'(write_enable), 32'(we));
        chk({tag, " fin"}, 32'(finished), 32'(fin));
    endtask

    task automatic tick(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            #1;
        end
    endtask

    int vals[LANES];
    int k;

    initial begin
        for (int i = 0; i < LANES; i++) vector_data[i*DATA_W +: DATA_W] = DATA_W'(50 + i);
        scalar_data = 10'd160;
        // reset state: outputs follow idx=0 with strobes low
        rst = 1'b0; op_type = 1'b1; base_address = 6'd34;
        tick(2);
        chk_all("reset", 34, 50, 0, 0);

        tbl[0]  = '{1, 0, 34, 34, 160, 1, 1, 1};
        tbl[1]  = '{1, 0, 34, 34, 160, 1, 1, 0};
        tbl[2]  = '{1, 1, 34, 34, 50, 1, 0, 1};
        tbl[3]  = '{1, 1, 34, 35, 51, 1, 0, 1};
        tbl[4]  = '{1, 1, 34, 36, 52, 1, 0, 1};
        tbl[5]  = '{1, 1, 34, 37, 53, 1, 0, 1};
        tbl[6]  = '{1, 1, 34, 38, 54, 1, 0, 0};
        tbl[7]  = '{0, 1, 34, 34, 50, 0, 0, 0};
        tbl[8]  = '{1, 1, 34, 34, 50, 1, 0, 1};
        tbl[9]  = '{1, 1, 34, 35, 51, 1, 0, 0};
        tbl[10] = '{1, 0, 34, 34, 160, 1, 1, 1};
        tbl[11] = '{1, 1, 34, 34, 50, 1, 0, 18};
        tbl[12] = '{1, 1, 34, 52, 68, 1, 0, 1};
        tbl[13] = '{1, 1, 34, 53, 69, 1, 1, 1};
        tbl[14] = '{1, 1, 34, 34, 50, 1, 0, 0};
        tbl[15] = '{1, 0, 62, 62, 160, 1, 1, 1};
        tbl[16] = '{1, 1, 62, 62, 50, 1, 0, 1};
        tbl[17] = '{1, 1, 62, 63, 51, 1, 0, 1};
        tbl[18] = '{1, 1, 62, 0, 52, 1, 0, 1};
        tbl[19] = '{1, 1, 62, 1, 53, 1, 0, 0};
        tbl[20] = '{1, 0, 62, 62, 160, 1, 1, 1};

        for (int r = 0; r < 21; r++) begin
            rst = tbl[r].r;
            op_type = tbl[r].op;
            base_address = ADDR_W'(tbl[r].base);
            #1;
            chk_all($sformatf("row%0d", r), tbl[r].ea, tbl[r].ed, tbl[r].we, tbl[r].fin);
            tick(tbl[r].post);
        end

        // randomized run against an element-counter model
        k = 0;
        for (int i = 0; i < LANES; i++) begin
            vals[i] = int'($urandom_range(0, 1023));
            vector_data[i*DATA_W +: DATA_W] = DATA_W'(vals[i]);
        end
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) >= 4);
            op_type = ($urandom_range(0, 99) < 80);
            scalar_data = DATA_W'($urandom_range(0, 1023));
            if (k == 0 && $urandom_range(0, 3) == 0) base_address = ADDR_W'($urandom_range(0, 63));
            if (!rst) k = 0;
            #1;
            chk_all("rand",
                    op_type ? (int'(base_address) + k) % (1 << ADDR_W) : int'(base_address),
                    op_type ? vals[k] : int'(scalar_data),
                    rst,
                    rst && (!op_type || k == LANES - 1));
            @(posedge clk);
            k = (!rst || !op_type) ? 0 : (k + 1) % LANES;
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
